// File: rtl/lbp_pkg.sv
// Shared types and constants for the LBP histogram stage and its address generator.
package lbp_pkg;

  localparam int IMG_W          = 8;
  localparam int BINS           = 16;
  localparam int CNT_W          = 6;
  localparam int ADDR_W         = $clog2(IMG_W * IMG_W);
  localparam int BIN_W          = $clog2(BINS);
  localparam int HIST_W         = 8;
  localparam int LBP_FIRST_ADDR = IMG_W + 1;
  localparam int LBP_LAST_ADDR  = (IMG_W - 2) * IMG_W + (IMG_W - 2);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    WRITE,
    DONE
  } state_e;

  // Saturating bin increment; holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/lbp_addr_gen.sv
// Interior-pixel address generator: walks rows/cols 1..IMG_W-2, skipping the
// border columns, and flags the last interior address.
module lbp_addr_gen
  import lbp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic              clear,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int POS_W = $clog2(IMG_W);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [POS_W-1:0]  row_q, row_d;
  logic [POS_W-1:0]  col_q, col_d;

  always_comb begin
    addr_d = addr_q;
    row_d  = row_q;
    col_d  = col_q;
    if (load) begin
      addr_d = ADDR_W'(LBP_FIRST_ADDR);
      row_d  = POS_W'(1);
      col_d  = POS_W'(1);
    end else if (clear) begin
      addr_d = '0;
      row_d  = '0;
      col_d  = '0;
    end else if (step) begin
      // At the last interior column, jump over right border and next left border.
      if (col_q == POS_W'(IMG_W - 2)) begin
        addr_d = addr_q + ADDR_W'(3);
        row_d  = row_q + POS_W'(1);
        col_d  = POS_W'(1);
      end else begin
        addr_d = addr_q + ADDR_W'(1);
        col_d  = col_q + POS_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      row_q  <= '0;
      col_q  <= '0;
    end else begin
      addr_q <= addr_d;
      row_q  <= row_d;
      col_q  <= col_d;
    end
  end

  assign addr = addr_q;
  assign last = (row_q == POS_W'(IMG_W - 2)) && (col_q == POS_W'(IMG_W - 2));

endmodule

// File: rtl/lbp_hist.sv
// Histogram of the upper nibble of the 36 interior LBP codes; writes the 16 bin
// counts out to histogram memory and pulses done.
module lbp_hist
  import lbp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              lbp_req,
  output logic [ADDR_W-1:0] lbp_rd_addr,
  input  logic [7:0]        lbp_rd_data,
  output logic [BIN_W-1:0]  hist_addr,
  output logic              hist_write,
  output logic [HIST_W-1:0] hist_data,
  output logic              busy,
  output logic              done
);

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   idx_q, idx_d;
  logic               rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0]   bin_q [BINS];
  logic [CNT_W-1:0]   bin_d [BINS];
  logic               lbp_req_q, lbp_req_d;
  logic               hist_write_q, hist_write_d;
  logic [BIN_W-1:0]   hist_addr_q, hist_addr_d;
  logic [HIST_W-1:0]  hist_data_q, hist_data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ag_load, ag_step, ag_clear, ag_last;
  logic               unused_low_nibble;

  assign unused_low_nibble = ^lbp_rd_data[3:0];

  lbp_addr_gen u_addr_gen (
    .clk   (clk),
    .reset (reset),
    .load  (ag_load),
    .step  (ag_step),
    .clear (ag_clear),
    .addr  (lbp_rd_addr),
    .last  (ag_last)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    bin_d      = bin_q;
    ag_load    = 1'b0;
    ag_step    = 1'b0;
    ag_clear   = 1'b0;
    rd_valid_d = (state_q == READ);

    // Read data lands one cycle after each READ cycle, including the DRAIN cycle.
    if (rd_valid_q) begin
      bin_d[lbp_rd_data[7:4]] = sat_inc(bin_q[lbp_rd_data[7:4]]);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          ag_load = 1'b1;
          for (int i = 0; i < BINS; i++) bin_d[i] = '0;
        end
      end
      READ: begin
        if (ag_last) begin
          state_d  = DRAIN;
          ag_clear = 1'b1;
        end else begin
          ag_step = 1'b1;
        end
      end
      DRAIN: begin
        state_d = WRITE;
        idx_d   = '0;
      end
      WRITE: begin
        if (idx_q == BIN_W'(BINS - 1)) state_d = DONE;
        else                           idx_d   = idx_q + BIN_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state.
    lbp_req_d    = (state_d == READ);
    busy_d       = (state_d == READ) || (state_d == DRAIN) || (state_d == WRITE);
    hist_write_d = (state_d == WRITE);
    hist_addr_d  = hist_write_d ? idx_d : '0;
    hist_data_d  = hist_write_d ? HIST_W'(bin_d[idx_d]) : '0;
    done_d       = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      rd_valid_q   <= 1'b0;
      for (int i = 0; i < BINS; i++) bin_q[i] <= '0;
      lbp_req_q    <= 1'b0;
      hist_write_q <= 1'b0;
      hist_addr_q  <= '0;
      hist_data_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      rd_valid_q   <= rd_valid_d;
      bin_q        <= bin_d;
      lbp_req_q    <= lbp_req_d;
      hist_write_q <= hist_write_d;
      hist_addr_q  <= hist_addr_d;
      hist_data_q  <= hist_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign lbp_req    = lbp_req_q;
  assign hist_write = hist_write_q;
  assign hist_addr  = hist_addr_q;
  assign hist_data  = hist_data_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_lbp_hist.sv
// Bench for lbp_hist: LBP memory responder, cycle-accurate reference model of
// the expected output timeline, and directed plus random histogram runs.
module tb_lbp_hist;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       lbp_req;
  logic [5:0] lbp_rd_addr;
  logic [7:0] lbp_rd_data;
  logic [3:0] hist_addr;
  logic       hist_write;
  logic [7:0] hist_data;
  logic       busy;
  logic       done;

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   run_p       = -1;
  bit   check_en    = 1'b0;
  int   exp_bins [16];
  int   cap_hist [16];
  int   write_count = 0;
  int   done_count  = 0;
  int   rel;
  logic [7:0] mem [64];

  lbp_hist dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .lbp_req     (lbp_req),
    .lbp_rd_addr (lbp_rd_addr),
    .lbp_rd_data (lbp_rd_data),
    .hist_addr   (hist_addr),
    .hist_write  (hist_write),
    .hist_data   (hist_data),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read LBP memory; garbage when not requested so it must be ignored.
  always @(posedge clk) lbp_rd_data <= (lbp_req === 1'b1) ? mem[lbp_rd_addr] : 8'($urandom);

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: actual %0d required %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic int interior_addr(input int n);
    return (1 + n / 6) * 8 + (1 + n % 6);
  endfunction

  function automatic void build_model();
    for (int b = 0; b < 16; b++) exp_bins[b] = 0;
    for (int n = 0; n < 36; n++) exp_bins[mem[interior_addr(n)][7:4]]++;
  endfunction

  // Expected output timeline relative to the accepted start (rel = k means cycle T+k).
  always @(negedge clk) begin
    if (check_en && reset === 1'b1) begin
      rel = (run_p < 0) ? 0 : cyc - run_p + 1;
      check_output("lbp_req", lbp_req, 32'(rel >= 1 && rel <= 36));
      check_output("busy", busy, 32'(rel >= 1 && rel <= 53));
      check_output("hist_write", hist_write, 32'(rel >= 38 && rel <= 53));
      check_output("done", done, 32'(rel == 54));
      if (rel >= 1 && rel <= 36) check_output("lbp_rd_addr", lbp_rd_addr, interior_addr(rel - 1));
      if (rel >= 38 && rel <= 53) begin
        check_output("hist_addr", hist_addr, rel - 38);
        check_output("hist_data", hist_data, exp_bins[rel - 38]);
      end
    end
    if (reset === 1'b1 && hist_write === 1'b1) begin
      cap_hist[hist_addr] = int'(hist_data);
      write_count++;
    end
    if (reset === 1'b1 && done === 1'b1) done_count++;
  end

  task automatic apply_stimulus(input int kind);
    for (int a = 0; a < 64; a++) mem[a] = 8'($urandom);
    for (int n = 0; n < 36; n++) begin
      case (kind)
        0:       mem[interior_addr(n)] = 8'h00;
        1:       mem[interior_addr(n)] = 8'(interior_addr(n));
        2:       mem[interior_addr(n)] = (n % 2 == 0) ? 8'hF0 : 8'h10;
        3:       mem[interior_addr(n)] = 8'hFF;
        default: mem[interior_addr(n)] = 8'($urandom);
      endcase
    end
  endtask

  // Call at a negedge; the model accepts only when no run is in flight.
  task automatic pulse_start();
    if (run_p < 0 || cyc - run_p + 1 >= 55) begin
      run_p = cyc + 1;
      build_model();
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_rel(input int k);
    int guard;
    guard = 0;
    while (cyc - run_p + 1 < k && guard < 200) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic clear_cap();
    for (int b = 0; b < 16; b++) cap_hist[b] = -1;
  endtask

  task automatic check_hist(input string tag);
    int sum;
    sum = 0;
    for (int b = 0; b < 16; b++) begin
      sum += cap_hist[b];
      check_output({tag, "_bin"}, cap_hist[b], exp_bins[b]);
    end
    check_output({tag, "_sum"}, sum, 36);
  endtask

  task automatic run_and_check(input string tag);
    int w0;
    int d0;
    clear_cap();
    w0 = write_count;
    d0 = done_count;
    pulse_start();
    repeat (55) @(negedge clk);
    check_output({tag, "_writes"}, write_count - w0, 16);
    check_output({tag, "_dones"}, done_count - d0, 1);
    check_hist(tag);
  endtask

  initial begin
    int w0;
    int d0;
    int lit [4];
    lit = '{6, 12, 12, 6};
    reset = 1'b1;
    start = 1'b0;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    check_output("rst_lbp_req", lbp_req, 0);
    check_output("rst_lbp_rd_addr", lbp_rd_addr, 0);
    check_output("rst_hist_addr", hist_addr, 0);
    check_output("rst_hist_write", hist_write, 0);
    check_output("rst_hist_data", hist_data, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    reset = 1'b1;
    check_en = 1'b1;
    repeat (2) @(negedge clk);

    apply_stimulus(0);
    run_and_check("zeros");
    check_output("zeros_model_bin0", exp_bins[0], 36);
    check_output("zeros_bin0_lit", cap_hist[0], 36);
    check_output("zeros_bin7_lit", cap_hist[7], 0);

    apply_stimulus(1);
    run_and_check("addr");
    for (int b = 0; b < 4; b++) check_output("addr_bin_lit", cap_hist[b], lit[b]);
    check_output("addr_bin4_lit", cap_hist[4], 0);

    apply_stimulus(2);
    run_and_check("alt");
    check_output("alt_bin15_lit", cap_hist[15], 18);
    check_output("alt_bin1_lit", cap_hist[1], 18);

    // Starts while busy and during DONE are ignored; the cycle after DONE is accepted.
    apply_stimulus(4);
    clear_cap();
    w0 = write_count;
    d0 = done_count;
    pulse_start();
    wait_rel(5);
    pulse_start();
    wait_rel(54);
    pulse_start();
    check_output("ign_writes", write_count - w0, 16);
    check_output("ign_dones", done_count - d0, 1);
    check_hist("ign");
    apply_stimulus(1);
    run_and_check("rerun");
    check_output("rerun_bin1_lit", cap_hist[1], 12);
    check_output("rerun_bin3_lit", cap_hist[3], 6);

    apply_stimulus(0);
    pulse_start();
    wait_rel(20);
    d0 = done_count;
    reset = 1'b0;
    run_p = -1;
    #1;
    check_output("midrst_lbp_req", lbp_req, 0);
    check_output("midrst_busy", busy, 0);
    check_output("midrst_hist_write", hist_write, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (60) @(negedge clk);
    check_output("midrst_no_done", done_count - d0, 0);
    apply_stimulus(3);
    run_and_check("ff");
    check_output("ff_bin15_lit", cap_hist[15], 36);

    for (int r = 0; r < 50; r++) begin
      apply_stimulus(4);
      run_and_check("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lbp_hist.md
Name: lbp_hist

Overview:
- Downstream consumer of the LBP stage.
- After the LBP stage asserts finish, this block reads the 36 interior LBP codes of the 8x8 LBP memory: rows 1..6, cols 1..6, addresses 9..14, 17..22, ..., 49..54.
- It builds a 16-bin histogram keyed on the code's upper nibble, writes the 16 bin counts to a histogram memory, then pulses done.
- Its output is the feature vector consumed by the later classifier stage.

Parameters:
- IMG_W, 8, image width/height in pixels. Address width is log2(IMG_W*IMG_W) = 6 at default.
- BINS, 16, number of histogram bins. Bin index = lbp_rd_data[7:4]. Fixed at 16 for this revision.
- CNT_W, 6, bin counter width. Must hold (IMG_W-2)^2 = 36.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  1-cycle pulse, tied to LBP finish
- lbp_req  output  1  LBP memory read enable
- lbp_rd_addr  output  6  LBP memory read address
- lbp_rd_data  input  8  LBP code; valid the cycle after lbp_req/lbp_rd_addr
- hist_addr  output  4  histogram memory write address
- hist_write  output  1  histogram memory write strobe
- hist_data  output  8  bin count, zero-extended from CNT_W
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  1-cycle completion pulse

Behaviour:
- Reset (reset=0, async): state IDLE.
  - All outputs 0; lbp_rd_addr=0, hist_addr=0.
  - All bins cleared; row/col counters cleared.
- All outputs are registered.
- States:
  - IDLE: wait for start=1. On start, go to READ, clear all 16 bins, set lbp_rd_addr=9, col=1.
  - READ: lbp_req=1, busy=1.
    - Each cycle the address advances +1. When col==6 it advances +3 instead (skips the border columns).
    - 36 addresses are issued: 9..54.
    - After address 54 is issued, go to DRAIN.
  - Accumulate: in every cycle following a READ cycle, bin[lbp_rd_data[7:4]] += 1.
    - The first data arrives in the second READ cycle.
    - The last data arrives in DRAIN.
  - DRAIN: lbp_req=0. Accumulate the final code, then go to WRITE with idx=0.
  - WRITE: 16 cycles, idx 0..15.
    - hist_write=1, hist_addr=idx, hist_data={2'b0,bin[idx]}.
    - After idx=15, go to DONE.
  - DONE: done=1, busy=0, hist_write=0. Next cycle go to IDLE.
- Latency: start sampled at cycle T gives:
  - READ at T+1..T+36
  - DRAIN at T+37
  - WRITE at T+38..T+53
  - done high at T+54
- Arithmetic:
  - Bin counters saturate at 2^CNT_W-1. This is unreachable at default sizes; the saturation logic is required for safety.
  - The sum of all bins after a run equals 36.
- Boundary conditions:
  - start while busy (READ/DRAIN/WRITE/DONE): ignored, no restart.
  - start in the same cycle as DONE: ignored. A start one cycle later, in IDLE, is accepted.
  - Back-to-back runs: bins are cleared on accept, so a second run never accumulates onto the first.
  - Identical bin hit in consecutive cycles: counted each time (single-cycle read-modify-write on the bin register array).
  - Reset asserted mid-run: immediate return to IDLE.
    - lbp_req and hist_write drop asynchronously.
    - No done pulse; the partial histogram is discarded.
  - lbp_rd_data is ignored in all cycles not following a READ cycle.

Decomposition:
- Shared package lbp_pkg holds:
  - state enum (IDLE, READ, DRAIN, WRITE, DONE)
  - IMG_W, BINS, CNT_W
  - LBP_FIRST_ADDR=9, LBP_LAST_ADDR=54
- Optional sub-module lbp_addr_gen: interior-pixel address generator (row/col counters, +1/+3 stepping, last flag). Shared with the LBP stage's border-skipping logic.
- Bin array and FSM live in lbp_hist.

Test Plan:
- All codes 0x00 after one start pulse:
  - hist bin0=36, bins 1..15=0
  - done exactly at T+54
  - read addresses exactly 9..14, 17..22, ..., 49..54 (36 reads, none outside)
- Codes = address value, so upper nibbles are 0..3: bin0=6 (9..14), bin1=12 (17..22, 25..30), bin2=12 (33..38, 41..46), bin3=6 (49..54), others 0.
- Alternating 0xF0/0x10 on consecutive reads: bin15=18, bin1=18. Checks consecutive-cycle accumulation and DRAIN capture of the last code.
- start pulses at T+5 and T+54 (DONE): both ignored; hist_write count=16, done count=1. Fresh start at T+56 gives a correct second histogram, with no carry-over from run 1.
- reset=0 at T+20 (mid-READ):
  - lbp_req, busy and hist_write go to 0 immediately
  - no done pulse
  - a following run with all codes 0xFF yields bin15=36
- Random codes over 50 runs: each histogram matches a reference model; the sum of bins is 36 every run.
